toggle_cube_fsm: RTL

Parametrised Mealy toggle state machine: a W-bit state vector in which each accepted input toggles exactly one selected state bit, so the state walks the edges of a W-dimensional hypercube and can oscillate between vertices. It generalises the team's fixed 4-state, 1-input oscillator (W=2: select 0 toggles bit 0, select 1 toggles bit 1, output equals the select). It adds input qualification, illegal-select detection, return-to-home counting and an optional lock after a configurable number of returns. It sits between input decode and the control blocks that consume the state vector.

---
 rtl/toggle_cube_pkg.sv | 20 ++
 rtl/toggle_cube_fsm_sat_counter.sv | 29 ++
 rtl/toggle_cube_fsm.sv | 121 ++++++++++++
 3 files changed

// File: rtl/toggle_cube_pkg.sv
// Shared helpers for toggle_cube_fsm: select-width computation and the
// parameter legality checks evaluated at elaboration time.
package toggle_cube_pkg;

    // Width of the bit-select input: max(1, clog2(w)).
    function automatic int unsigned sel_w(input int unsigned w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

    // State width must lie in 1..16.
    function automatic bit w_ok(input int unsigned w);
        return (w >= 1) && (w <= 16);
    endfunction

    // The lock threshold must be representable by the return counter.
    function automatic bit limit_ok(input int unsigned lim, input int unsigned cw);
        return (cw >= 1) && (cw < 64) && (64'(lim) < (64'd1 << cw));
    endfunction

endpackage

// File: rtl/toggle_cube_fsm_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), clr (sync clear), inc (count enable),
//        cnt (current count, sticks at all-ones).
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over increment; increment stops at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/toggle_cube_fsm.sv
// toggle_cube_fsm: W-bit hypercube toggle machine. Each accepted input flips
// one state bit; returns to the all-zero vertex are counted and can lock the
// machine after LIMIT returns (LIMIT=0 disables locking).
// Ports: clk, rst (sync, active-high), in_vld/in_sel (toggle request),
//        clr (clear return count and lock), state, y (Mealy output),
//        home (return pulse), ret_cnt, locked, err (illegal-select pulse).
// Build option: TOGGLE_CUBE_REG_Y_EN registers y (one-cycle latency).
module toggle_cube_fsm
    import toggle_cube_pkg::*;
#(
    parameter  int unsigned W     = 2,
    parameter  int unsigned CNT_W = 8,
    parameter  int unsigned LIMIT = 0,
    localparam int unsigned SEL_W = sel_w(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             clr,
    output logic [W-1:0]     state,
    output logic             y,
    output logic             home,
    output logic [CNT_W-1:0] ret_cnt,
    output logic             locked,
    output logic             err
);

    if (!w_ok(W)) begin : g_bad_w
        $error("toggle_cube_fsm: W must be in 1..16");
    end
    if (!limit_ok(LIMIT, CNT_W)) begin : g_bad_limit
        $error("toggle_cube_fsm: LIMIT must be below 2**CNT_W");
    end

    logic [W-1:0]     r_state;
    logic [W-1:0]     w_state_nxt;
    logic             r_home;
    logic             r_err;
    logic             r_locked;
    logic             w_legal;
    logic             w_accept;
    logic             w_home_evt;
    logic             w_err_evt;
    logic             w_lock_set;
    logic             w_y_c;
    logic [CNT_W-1:0] w_cnt;

    assign w_legal = (32'(in_sel) < W);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= '0;
            r_home   <= 1'b0;
            r_err    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_home  <= w_home_evt;
            r_err   <= w_err_evt;
            if (clr) begin
                r_locked <= 1'b0;
            end else if (w_lock_set) begin
                r_locked <= 1'b1;
            end
        end
    end

    // Next-state: clr and lock both drop the request.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = in_vld & w_legal & ~r_locked & ~clr;
        if (w_accept) begin
            w_state_nxt = r_state ^ (W'(1) << in_sel);
        end
        w_home_evt = w_accept & (w_state_nxt == '0) & (r_state != '0);
        w_err_evt  = in_vld & ~w_legal;
        // The edge that brings the counter to LIMIT is the one that locks.
        w_lock_set = (LIMIT != 0) & w_home_evt & (w_cnt == CNT_W'(LIMIT - 1));
    end

    // Mealy output.
    always_comb begin
        w_y_c = 1'b0;
        w_y_c = in_vld & (in_sel != '0) & ~r_locked & w_legal;
    end

`ifdef TOGGLE_CUBE_REG_Y_EN
    logic r_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y <= 1'b0;
        end else begin
            r_y <= w_y_c;
        end
    end

    assign y = r_y;
`else
    assign y = w_y_c;
`endif

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_ret_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_home_evt),
        .cnt (w_cnt)
    );

    assign state   = r_state;
    assign home    = r_home;
    assign ret_cnt = w_cnt;
    assign locked  = r_locked;
    assign err     = r_err;

endmodule
